digit_scan: RTL
===============

DIGIT_SCAN -- requirements
Module: digit_scan

Interface
REQ-001 Parameter DIV, default 50000, meaning: clock cycles per digit slot, legal range 2..2^20.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low, sampled on the rising edge of clk.
REQ-004 load  input  1  request to capture data_in, sampled each cycle when high.
REQ-005 data_in  input  16  four hex nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-006 dp_in  input  4  decimal-point flags, captured alongside data_in; bit k belongs to digit k.
REQ-007 lzs  input  1  leading-zero suppression enable, used live (not captured).
REQ-008 en  input  1  display enable; 0 forces all anodes off.
REQ-009 nibble  output  4  hex value of the active digit, feeds the 4-bit-to-seven-segment decoder.
REQ-010 an  output  4  active-low anode enables, at most one bit low.
REQ-011 dp  output  1  active-high decimal point of the active digit.
REQ-012 pending  output  1  high while a captured value awaits commit to the display.

Function
REQ-013 A prescaler SHALL count 0..DIV-1 and wrap to 0; tick SHALL be high in the cycle count==DIV-1.
REQ-014 Digit index idx (2 bits) SHALL advance by 1 on each tick, wrapping from 3 to 0.
REQ-015 load=1 SHALL write data_in/dp_in into the shadow register and set pending=1 in the next cycle.
REQ-016 load=1 while pending=1 SHALL overwrite the shadow register (last write wins); pending stays 1.
REQ-017 Commit: on a tick with idx==3 and pending=1, the display register SHALL take the shadow value and pending SHALL clear; the display register SHALL NOT change at any other time (no tearing within a frame).
REQ-018 load and commit in the same cycle: commit SHALL use the old shadow value, the new data goes into the shadow register, and pending SHALL remain 1.
REQ-019 nibble SHALL equal display nibble idx and dp SHALL equal display dp bit idx; both SHALL be driven only from registers (no path from any input to any output).
REQ-020 an SHALL be all ones except bit idx, which SHALL be 0, when en=1 and the digit is not suppressed.
REQ-021 With lzs=1, digit k (k=1..3) SHALL be suppressed (an bit k high) when display nibbles k..3 are all zero; digit 0 SHALL never be suppressed.
REQ-022 en=0 SHALL force an=4'b1111; the prescaler, idx, load and commit SHALL continue unaffected.
REQ-023 Frame period SHALL be exactly 4*DIV cycles; each digit SHALL be active for exactly DIV consecutive cycles.

Reset
REQ-024 rst_n=0 SHALL set prescaler=0, idx=0, display=0, shadow=0, pending=0, so outputs are nibble=0, dp=0, an=4'b1110 (4'b1111 if en=0).
REQ-025 Reset during a pending capture SHALL discard the shadow value; load in a reset cycle SHALL be ignored.

Structure
REQ-026 A shared package SHALL hold NDIG=4, NIB_W=4, AN_OFF=4'b1111 and the digit-index type.
REQ-027 The prescaler SHALL be a sub-module tick_gen (parameter DIV; ports clk, rst_n, tick).

Verification (DIV=4)
REQ-028 Reset then en=1, lzs=0 -> an cycles 1110,1101,1011,0111 for 4 cycles each, frame of 16 cycles, nibble=0.
REQ-029 load with data_in=16'h12AF mid-frame -> pending=1 next cycle; display stays 0000 until the idx 3->0 tick, then nibble sequence F,A,2,1 and pending=0.
REQ-030 Two loads (16'h1111, then 16'h2222) before commit -> only 2222 is displayed; 1111 never appears.
REQ-031 load on the commit-tick cycle (shadow=16'h3333, data_in=16'h4444) -> 3333 displayed, pending stays 1, 4444 displayed one frame later.
REQ-032 lzs=1, display=16'h0050 -> an bit 3 and bit 2 stay high, digits 1 and 0 light; display=16'h0000 -> only digit 0 lights with nibble 0.
REQ-033 en=0 for one frame, then rst_n=0 mid-frame with pending=1 -> an=1111 throughout en=0; after reset an=1110, pending=0, display=0.

Source files
------------

// File: rtl/digit_scan_pkg.sv
// Shared constants, digit-index type and small helpers for the digit scanner.
package digit_scan_pkg;

  localparam int NDIG   = 4;
  localparam int NIB_W  = 4;
  localparam int DATA_W = NDIG * NIB_W;
  localparam logic [NDIG-1:0] AN_OFF = 4'b1111;

  typedef logic [1:0] digit_idx_t;

  // Hex value of digit k inside a packed display word.
  function automatic logic [NIB_W-1:0] pickNibble(input logic [DATA_W-1:0] word,
                                                  input digit_idx_t k);
    return word[int'(k)*NIB_W +: NIB_W];
  endfunction

  // A digit is blank when it and every digit to its left are zero; digit 0 always shows.
  function automatic logic isSuppressed(input logic [DATA_W-1:0] word,
                                        input digit_idx_t k);
    logic nonZero;
    nonZero = 1'b0;
    for (int j = 0; j < NDIG; j++) begin
      if (j >= int'(k) && word[j*NIB_W +: NIB_W] != '0) nonZero = 1'b1;
    end
    return (int'(k) != 0) && !nonZero;
  endfunction

  // Active-low anode pattern for digit k given enable and leading-zero blanking.
  function automatic logic [NDIG-1:0] anodeFor(input digit_idx_t k,
                                               input logic en,
                                               input logic lzs,
                                               input logic [DATA_W-1:0] word);
    if (!en || (lzs && isSuppressed(word, k))) return AN_OFF;
    return ~(NDIG'(1) << k);
  endfunction

endpackage

// File: rtl/digit_scan_if.sv
// Bus between the display driver client and the digit scanner.
interface digit_scan_if;
  import digit_scan_pkg::*;

  logic                  load;
  logic [DATA_W-1:0]     data_in;
  logic [NDIG-1:0]       dp_in;
  logic                  lzs;
  logic                  en;
  logic [NIB_W-1:0]      nibble;
  logic [NDIG-1:0]       an;
  logic                  dp;
  logic                  pending;

  modport master (output load, data_in, dp_in, lzs, en,
                  input  nibble, an, dp, pending);

  modport slave  (input  load, data_in, dp_in, lzs, en,
                  output nibble, an, dp, pending);

endinterface

// File: rtl/digit_scan_tick_gen.sv
// Prescaler producing a one-cycle tick every DIV clock cycles.
module tick_gen #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] r_count;

  assign tick = (r_count == CW'(DIV - 1));

  // Count 0..DIV-1 and wrap back to zero on the tick cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/digit_scan.sv
// Four-digit multiplexed display scanner with double-buffered, frame-aligned update.
module digit_scan
  import digit_scan_pkg::*;
#(
  parameter int DIV = 50000
) (
  input  logic         clk,
  input  logic         rst_n,
  digit_scan_if.slave  bus
);

  logic              w_tick;
  logic              w_commit;
  digit_idx_t        w_idxNext;
  logic [DATA_W-1:0] w_dispNext;
  logic [NDIG-1:0]   w_dispDpNext;

  digit_idx_t        r_idx;
  logic [DATA_W-1:0] r_shadow;
  logic [NDIG-1:0]   r_shadowDp;
  logic              r_pending;
  logic [DATA_W-1:0] r_disp;
  logic [NDIG-1:0]   r_dispDp;
  logic [NIB_W-1:0]  r_nibble;
  logic              r_dp;
  logic [NDIG-1:0]   r_an;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick)
  );

  // Next digit index and display contents; the display only changes at a frame boundary.
  always_comb begin
    w_commit     = w_tick && (r_idx == digit_idx_t'(NDIG - 1)) && r_pending;
    w_idxNext    = w_tick ? digit_idx_t'(r_idx + 2'd1) : r_idx;
    w_dispNext   = w_commit ? r_shadow   : r_disp;
    w_dispDpNext = w_commit ? r_shadowDp : r_dispDp;
  end

  // Scan index, shadow capture and display commit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_shadow   <= '0;
      r_shadowDp <= '0;
      r_pending  <= 1'b0;
      r_disp     <= '0;
      r_dispDp   <= '0;
    end else begin
      r_idx    <= w_idxNext;
      r_disp   <= w_dispNext;
      r_dispDp <= w_dispDpNext;
      if (bus.load) begin
        r_shadow   <= bus.data_in;
        r_shadowDp <= bus.dp_in;
      end
      r_pending <= bus.load | (r_pending & ~w_commit);
    end
  end

  // Register the visible outputs from the state they will accompany next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_nibble <= '0;
      r_dp     <= 1'b0;
      r_an     <= anodeFor(digit_idx_t'(0), bus.en, bus.lzs, '0);
    end else begin
      r_nibble <= pickNibble(w_dispNext, w_idxNext);
      r_dp     <= w_dispDpNext[w_idxNext];
      r_an     <= anodeFor(w_idxNext, bus.en, bus.lzs, w_dispNext);
    end
  end

  assign bus.nibble  = r_nibble;
  assign bus.dp      = r_dp;
  assign bus.an      = r_an;
  assign bus.pending = r_pending;

endmodule
